ex_muldiv: RTL
==============

Name: ex_muldiv

Overview:
- Iterative multiply/divide unit in the execute stage, directly upstream of the memory-access stage of the single-clock MIPS.
- Owns the HI/LO registers and executes MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO.
- Asserts Stall to freeze PC and the instruction while an operation is in flight.
- Its MD_Result is muxed into the ALU Result path that feeds memory access.

Parameters:
- XLEN, 32, operand/HI/LO width
- ITER, 32, iterations per mult/div (must equal XLEN)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-low reset
- En  in  1  instruction valid this cycle
- Ins  in  32  current instruction
- Rdata1  in  32  rs value
- Rdata2  in  32  rt value
- Stall  out  1  hold PC/Ins; combinational from state + decode
- MD_Sel  out  1  1 when Ins is MFHI/MFLO (Result mux select)
- MD_Result  out  32  HI for MFHI, LO for MFLO, else 0
- HI  out  32  HI register
- LO  out  32  LO register

Behaviour:
- Decode: Ins[31:26]=000000 with funct 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010000 MFHI, 010010 MFLO, 010001 MTHI, 010011 MTLO. Any other Ins is a no-op for this block.
- Reset (RST=0, async): state IDLE, counter 0, HI=0, LO=0, internal operand registers 0, Stall=0. Reset mid-operation aborts the operation; HI/LO read 0.
- States: IDLE, BUSY, DONE.
- IDLE, start condition: En=1 and a mult/div op is decoded.
  - Stall=1 combinationally in the issue cycle.
  - At the clock edge: latch |Rdata1| and |Rdata2| (signed ops), record result sign and op, set counter=0, go to BUSY.
- BUSY: Stall=1. One shift-add (mult) or restoring shift-subtract (div) step per cycle; counter increments each cycle. After step ITER-1, write HI/LO at the edge and go to DONE.
  - Mult: {HI,LO} = 64-bit product, negated if signed and the operand signs differ.
  - Div: LO = quotient (sign = s1^s2), HI = remainder (sign of dividend).
- DONE: Stall=0 for exactly one cycle so the held instruction retires without re-issuing; go to IDLE at the next edge. En/Ins are ignored for issue in DONE.
- Latency: 1 issue cycle + 32 BUSY cycles stalled (Stall high 33 cycles); HI/LO valid from the DONE cycle.
- MTHI/MTLO: in IDLE or DONE with En=1, HI or LO := Rdata1 at the edge. No stall.
- MFHI/MFLO: combinational, MD_Sel=1 and MD_Result = current HI/LO, no stall. Never coincides with BUSY because Stall holds Ins.
- Divide by zero: LO=0xFFFFFFFF, HI=dividend (signed: original Rdata1). Still 32 cycles.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- En=0: no issue, no MT writes; an in-flight operation continues.

Optional Feature:
- Macro: MD_EARLY_OUT_EN
- Defined:
  - Multiply leaves BUSY as soon as the remaining multiplier bits are all zero. The product is still correct, with the result written at that edge and then one DONE cycle.
  - Multiply by 0 gives issue + 1 BUSY cycle; Stall is high 2 cycles.
  - Divide timing is unchanged.
- Undefined: every multiply and divide takes the full ITER BUSY cycles.

Test Plan:
- MULT with Rdata1=0xFFFFFFFD (-3), Rdata2=7 -> Stall high 33 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB; Stall=0 for one DONE cycle, then IDLE.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. DIVU 100/7 -> LO=14, HI=2.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 5/0 -> LO=0xFFFFFFFF, HI=5. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI Rdata1=0x12345678, then MFHI -> MD_Sel=1, MD_Result=0x12345678 with no stall. MTLO then MFLO round-trips the same way.
- Start MULT, drop RST at BUSY cycle 10 -> immediately Stall=0, HI=LO=0, state IDLE. Release reset with MULT still on Ins -> a fresh 33-cycle operation starts.
- MD_EARLY_OUT_EN defined: MULTU 5*3 -> Stall high 3 cycles, LO=15, HI=0. Undefined: same op -> Stall high 33 cycles.

Source files
------------

// File: rtl/ex_muldiv.sv
// Iterative MIPS multiply/divide unit owning HI/LO; stalls the front end while busy.
// Optional `MD_EARLY_OUT_EN`: multiplies finish once the remaining multiplier bits are zero.
module ex_muldiv #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            En,
    input  logic [31:0]     Ins,
    input  logic [XLEN-1:0] Rdata1,
    input  logic [XLEN-1:0] Rdata2,
    output logic            Stall,
    output logic            MD_Sel,
    output logic [XLEN-1:0] MD_Result,
    output logic [XLEN-1:0] HI,
    output logic [XLEN-1:0] LO
);

    localparam int CW = $clog2(ITER);

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [2*XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0]     mplr_q, mplr_d;
    logic                op_div_q, op_div_d;
    logic                neg_res_q, neg_res_d;
    logic                neg_rem_q, neg_rem_d;
    logic                div_zero_q, div_zero_d;
    logic [XLEN-1:0]     hi_q, hi_d;
    logic [XLEN-1:0]     lo_q, lo_d;

    // Instruction decode
    logic       special;
    logic [5:0] funct;
    logic       dec_mult, dec_multu, dec_div, dec_divu, dec_md, dec_signed;
    logic       dec_mfhi, dec_mflo, dec_mthi, dec_mtlo;

    assign special    = (Ins[31:26] == 6'b000000);
    assign funct      = Ins[5:0];
    assign dec_mult   = special && (funct == F_MULT);
    assign dec_multu  = special && (funct == F_MULTU);
    assign dec_div    = special && (funct == F_DIV);
    assign dec_divu   = special && (funct == F_DIVU);
    assign dec_mfhi   = special && (funct == F_MFHI);
    assign dec_mflo   = special && (funct == F_MFLO);
    assign dec_mthi   = special && (funct == F_MTHI);
    assign dec_mtlo   = special && (funct == F_MTLO);
    assign dec_md     = dec_mult || dec_multu || dec_div || dec_divu;
    assign dec_signed = dec_mult || dec_div;

    logic start, mt_ok;
    assign start = (state_q == S_IDLE) && En && dec_md;
    assign mt_ok = En && ((state_q == S_IDLE) || (state_q == S_DONE));

    logic            s1, s2;
    logic [XLEN-1:0] mag1, mag2;
    assign s1   = dec_signed && Rdata1[XLEN-1];
    assign s2   = dec_signed && Rdata2[XLEN-1];
    assign mag1 = s1 ? -Rdata1 : Rdata1;
    assign mag2 = s2 ? -Rdata2 : Rdata2;

    // One iteration: shift-add for multiply, restoring shift-subtract for divide
    logic [XLEN:0]     shifted;
    logic [XLEN+1:0]   diff;
    logic [2*XLEN-1:0] acc_n, mcand_n;
    logic [XLEN-1:0]   mplr_n;

    assign shifted = {acc_q[XLEN-1:0], mplr_q[XLEN-1]};
    assign diff    = {1'b0, shifted} - {2'b00, mcand_q[XLEN-1:0]};

    always_comb begin
        acc_n   = acc_q;
        mcand_n = mcand_q;
        mplr_n  = mplr_q;
        if (op_div_q) begin
            if (!diff[XLEN+1]) begin
                acc_n  = {{XLEN{1'b0}}, diff[XLEN-1:0]};
                mplr_n = {mplr_q[XLEN-2:0], 1'b1};
            end else begin
                acc_n  = {{XLEN{1'b0}}, shifted[XLEN-1:0]};
                mplr_n = {mplr_q[XLEN-2:0], 1'b0};
            end
        end else begin
            if (mplr_q[0]) acc_n = acc_q + mcand_q;
            mcand_n = mcand_q << 1;
            mplr_n  = mplr_q >> 1;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{Ins[25:6], diff[XLEN], shifted[XLEN]};

    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   rem_n, res_hi, res_lo;
    assign prod_s = neg_res_q ? -acc_n : acc_n;
    assign rem_n  = acc_n[XLEN-1:0];
    assign res_hi = op_div_q ? (neg_rem_q ? -rem_n : rem_n) : prod_s[2*XLEN-1:XLEN];
    assign res_lo = op_div_q ? (div_zero_q ? '1 : (neg_res_q ? -mplr_n : mplr_n))
                             : prod_s[XLEN-1:0];

    logic last_step;
`ifdef MD_EARLY_OUT_EN
    assign last_step = (cnt_q == CW'(ITER - 1)) || (!op_div_q && (mplr_n == '0));
`else
    assign last_step = (cnt_q == CW'(ITER - 1));
`endif

    logic stall_raw;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplr_d     = mplr_q;
        op_div_d   = op_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        stall_raw  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    stall_raw  = 1'b1;
                    state_d    = S_BUSY;
                    cnt_d      = '0;
                    acc_d      = '0;
                    op_div_d   = dec_div || dec_divu;
                    neg_res_d  = s1 ^ s2;
                    neg_rem_d  = s1;
                    div_zero_d = (Rdata2 == '0);
                    if (dec_div || dec_divu) begin
                        mcand_d = {{XLEN{1'b0}}, mag2};
                        mplr_d  = mag1;
                    end else begin
                        mcand_d = {{XLEN{1'b0}}, mag1};
                        mplr_d  = mag2;
                    end
                end
            end
            S_BUSY: begin
                stall_raw = 1'b1;
                acc_d     = acc_n;
                mcand_d   = mcand_n;
                mplr_d    = mplr_n;
                cnt_d     = cnt_q + CW'(1);
                if (last_step) begin
                    state_d = S_DONE;
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (mt_ok && dec_mthi) hi_d = Rdata1;
        if (mt_ok && dec_mtlo) lo_d = Rdata1;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplr_q     <= '0;
            op_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplr_q     <= mplr_d;
            op_div_q   <= op_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    // Stall is forced low while reset is held, even with a mult/div on Ins
    assign Stall     = RST && stall_raw;
    assign MD_Sel    = dec_mfhi || dec_mflo;
    assign MD_Result = dec_mfhi ? hi_q : (dec_mflo ? lo_q : '0);
    assign HI        = hi_q;
    assign LO        = lo_q;

endmodule
